// File: rtl/dense_activation_streamer.sv
// dense_activation_streamer
//
// Sits after the dense layer. It captures the whole dense output vector and
// the per-engine bias in one cycle. It then streams one activated element per
// valid/ready transfer. Activation means bias add, saturation to N bits and an
// optional ReLU. While streaming it tracks the running argmax, which gives the
// predicted class after the final layer.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous reset, active low
//   capture_i      latch dense_i/bias_i/relu_en_i (only honoured in IDLE)
//   dense_i        EngineCount packed signed N-bit dense outputs (element i at [i*N +: N])
//   bias_i         EngineCount packed signed N-bit biases, same packing
//   relu_en_i      clamp negative results to zero for this vector
//   busy_o         high while streaming and during the DONE cycle
//   valid_o        data_o/index_o hold a valid element
//   ready_i        consumer accepts; a transfer is valid_o && ready_i
//   data_o         activated element
//   index_o        engine index of data_o
//   last_o         current element is the final one of the vector
//   argmax_o       index of the largest activated value seen so far
//   argmax_valid_o one-cycle pulse when argmax_o is final

module dense_activation_streamer #(
  parameter int N           = 16,
  parameter int EngineCount = 10,
  localparam int IW         = $clog2(EngineCount)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     capture_i,
  input  logic [EngineCount*N-1:0] dense_i,
  input  logic [EngineCount*N-1:0] bias_i,
  input  logic                     relu_en_i,
  output logic                     busy_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [N-1:0]             data_o,
  output logic [IW-1:0]            index_o,
  output logic                     last_o,
  output logic [IW-1:0]            argmax_o,
  output logic                     argmax_valid_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_INDEX = IW'(EngineCount - 1);

  state_t             state;
  logic signed [N-1:0] dense_q [EngineCount];
  logic signed [N-1:0] bias_q  [EngineCount];
  logic                relu_q;
  logic signed [N-1:0] max_q;
  logic [IW-1:0]       index_next;

  assign index_next = index_o + IW'(1);

  // The sum is formed one bit wider, so it can never wrap. It is then clamped
  // into the N-bit signed range before the optional ReLU is applied.
  function automatic logic [N-1:0] activate(input logic signed [N-1:0] d,
                                            input logic signed [N-1:0] b,
                                            input logic relu);
    logic signed [N:0] sum;
    logic [N-1:0]      res;
    sum = {d[N-1], d} + {b[N-1], b};
    if (sum[N] != sum[N-1]) begin
      // The top two bits disagree, so the sum overflowed. The sign picks the rail.
      res = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      res = sum[N-1:0];
    end
    if (relu && res[N-1]) begin
      res = '0;
    end
    return res;
  endfunction

  // A single FSM owns every output register.
  // data_o is preloaded with the next element when a transfer happens, so it
  // holds its value while the consumer stalls.
  // The argmax takes the current element on its transfer. The first element
  // always seeds the max. A later element wins only when it is strictly larger.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      valid_o        <= 1'b0;
      busy_o         <= 1'b0;
      data_o         <= '0;
      index_o        <= '0;
      last_o         <= 1'b0;
      argmax_o       <= '0;
      argmax_valid_o <= 1'b0;
      max_q          <= '0;
      relu_q         <= 1'b0;
      for (int i = 0; i < EngineCount; i++) begin
        dense_q[i] <= '0;
        bias_q[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          argmax_valid_o <= 1'b0;
          if (capture_i) begin
            for (int i = 0; i < EngineCount; i++) begin
              dense_q[i] <= dense_i[i*N +: N];
              bias_q[i]  <= bias_i[i*N +: N];
            end
            relu_q   <= relu_en_i;
            index_o  <= '0;
            data_o   <= activate(dense_i[N-1:0], bias_i[N-1:0], relu_en_i);
            valid_o  <= 1'b1;
            busy_o   <= 1'b1;
            last_o   <= 1'b0;
            max_q    <= '0;
            argmax_o <= '0;
            state    <= STREAM;
          end
        end

        STREAM: begin
          if (ready_i) begin
            if (index_o == '0 || $signed(data_o) > max_q) begin
              max_q    <= $signed(data_o);
              argmax_o <= index_o;
            end
            if (index_o == LAST_INDEX) begin
              valid_o        <= 1'b0;
              last_o         <= 1'b0;
              argmax_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              index_o <= index_next;
              data_o  <= activate(dense_q[index_next], bias_q[index_next], relu_q);
              last_o  <= (index_next == LAST_INDEX);
            end
          end
        end

        DONE: begin
          argmax_valid_o <= 1'b0;
          busy_o         <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_activation_streamer.sv
// tb_dense_activation_streamer
//
// Drives dense_activation_streamer with EngineCount=4 and N=16.
// applyStimulus captures a vector and pushes the expected elements into a
// scoreboard queue, using an independent integer model of the activation.
// runStream plays consumer and pops the queue on every transfer.
// All comparisons go through checkOutput.

module tb_dense_activation_streamer;

  localparam int N  = 16;
  localparam int EC = 4;
  localparam int IW = $clog2(EC);

  typedef struct {
    logic [N-1:0]  data;
    logic [IW-1:0] index;
    logic          last;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             capture_i = 1'b0;
  logic [EC*N-1:0]  dense_i = '0;
  logic [EC*N-1:0]  bias_i = '0;
  logic             relu_en_i = 1'b0;
  logic             busy_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [N-1:0]     data_o;
  logic [IW-1:0]    index_o;
  logic             last_o;
  logic [IW-1:0]    argmax_o;
  logic             argmax_valid_o;

  exp_t exp_q[$];
  int   exp_argmax;
  int   tests_run = 0;
  int   tests_failed = 0;

  dense_activation_streamer #(.N(N), .EngineCount(EC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .capture_i      (capture_i),
    .dense_i        (dense_i),
    .bias_i         (bias_i),
    .relu_en_i      (relu_en_i),
    .busy_o         (busy_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .index_o        (index_o),
    .last_o         (last_o),
    .argmax_o       (argmax_o),
    .argmax_valid_o (argmax_valid_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive a capture for one edge and push the expected stream plus argmax
  task automatic applyStimulus(input logic [EC*N-1:0] d, input logic [EC*N-1:0] b, input logic relu);
    int   s;
    int   best;
    exp_t e;
    @(negedge clk_i);
    dense_i   = d;
    bias_i    = b;
    relu_en_i = relu;
    capture_i = 1'b1;
    ready_i   = 1'b1;
    best      = 0;
    for (int i = 0; i < EC; i++) begin
      s = int'($signed(d[i*N +: N])) + int'($signed(b[i*N +: N]));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      if (i == 0 || s > best) begin
        best       = s;
        exp_argmax = i;
      end
      e.data  = s[N-1:0];
      e.index = IW'(i);
      e.last  = (i == EC - 1);
      exp_q.push_back(e);
    end
  endtask

  // Act as the consumer until argmax_valid_o, optionally stalling and
  // poking capture_i while busy; bounded by a cycle budget
  task automatic runStream(input int stall_idx, input int stall_len, input bit cap_stream, input bit cap_done);
    int            cycles = 0;
    int            stall_left = 0;
    bit            stall_used = 0;
    bit            was_stalled = 0;
    bit            cap_sent = 0;
    bit            done = 0;
    logic [N-1:0]  held_data = '0;
    logic [IW-1:0] held_index = '0;
    exp_t          e;
    while (!done && cycles < 60) begin
      @(negedge clk_i);
      cycles++;
      capture_i = 1'b0;
      if (argmax_valid_o) begin
        checkOutput("argmax", 32'(argmax_o), 32'(exp_argmax));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        if (stall_len == 0) checkOutput("throughput", 32'(cycles), 32'(EC + 1));
        if (cap_done) begin
          dense_i   = {EC{16'h7000}};
          capture_i = 1'b1;
        end
        done = 1;
      end else if (valid_o) begin
        if (was_stalled) begin
          checkOutput("stall_data", 32'(data_o), 32'(held_data));
          checkOutput("stall_index", 32'(index_o), 32'(held_index));
        end
        if (int'(index_o) == stall_idx && !stall_used) begin
          stall_left = stall_len;
          stall_used = 1;
        end
        if (stall_left > 0) begin
          ready_i     = 1'b0;
          stall_left--;
          was_stalled = 1;
          held_data   = data_o;
          held_index  = index_o;
        end else begin
          ready_i     = 1'b1;
          was_stalled = 0;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_element", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("data", 32'(data_o), 32'(e.data));
            checkOutput("index", 32'(index_o), 32'(e.index));
            checkOutput("last", 32'(last_o), 32'(e.last));
          end
        end
        if (cap_stream && !cap_sent && index_o == IW'(1)) begin
          dense_i   = {EC{16'h1234}};
          bias_i    = {EC{16'h0100}};
          capture_i = 1'b1;
          cap_sent  = 1;
        end
      end
    end
    if (!done) checkOutput("stream_timeout", 32'd1, 32'd0);
    @(negedge clk_i);
    capture_i = 1'b0;
    ready_i   = 1'b1;
    checkOutput("idle_busy", 32'(busy_o), 32'd0);
    checkOutput("idle_valid", 32'(valid_o), 32'd0);
    checkOutput("idle_argmax_hold", 32'(argmax_o), 32'(exp_argmax));
  endtask

  initial begin
    int wait_cycles;

    // Reset state
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_data", 32'(data_o), 32'd0);
    checkOutput("rst_index", 32'(index_o), 32'd0);
    checkOutput("rst_last", 32'(last_o), 32'd0);
    checkOutput("rst_argmax", 32'(argmax_o), 32'd0);
    checkOutput("rst_argmax_valid", 32'(argmax_valid_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Basic stream
    applyStimulus({16'(7), 16'(100), 16'(-3), 16'(5)}, '0, 1'b0);
    runStream(-1, 0, 1'b0, 1'b0);

    // ReLU and bias, all zero so the tie keeps index 0
    applyStimulus({16'(0), 16'(-1), 16'(4), 16'(-10)}, {16'(0), 16'(0), 16'(-4), 16'(3)}, 1'b1);
    runStream(-1, 0, 1'b0, 1'b0);

    // Saturation at both rails
    applyStimulus({16'(100), 16'(0), 16'h8000, 16'h7FFF}, {16'(-5), 16'(0), 16'(-1), 16'(1)}, 1'b0);
    runStream(-1, 0, 1'b0, 1'b0);

    // Backpressure at index 1 for 3 cycles
    applyStimulus({16'(-4), 16'(3), 16'(2), 16'(1)}, '0, 1'b0);
    runStream(1, 3, 1'b0, 1'b0);

    // Capture pulses during STREAM and DONE are ignored; equal maxima keep lower index
    applyStimulus({16'(20), 16'(5), 16'(20), 16'(10)}, '0, 1'b0);
    runStream(-1, 0, 1'b1, 1'b1);
    checkOutput("done_capture_ignored", 32'(busy_o), 32'd0);

    // Reset mid-stream at index 2
    applyStimulus({16'(9), 16'(8), 16'(7), 16'(6)}, '0, 1'b0);
    wait_cycles = 0;
    do begin
      @(negedge clk_i);
      capture_i = 1'b0;
      wait_cycles++;
    end while (!(valid_o && index_o == IW'(2)) && wait_cycles < 20);
    if (wait_cycles >= 20) checkOutput("reset_wait_timeout", 32'd1, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(valid_o), 32'd0);
    checkOutput("midrst_argmax", 32'(argmax_o), 32'd0);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("midrst_no_pulse", 32'(argmax_valid_o), 32'd0);
    end
    rst_i = 1'b1;
    @(negedge clk_i);

    // Fresh capture after reset release
    applyStimulus({16'(7), 16'(100), 16'(-3), 16'(5)}, '0, 1'b0);
    runStream(-1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
